// File: rtl/mult_booth_if.sv
// Operand/control/result bundle for the sequential Booth multiplier;
// master is the requester, slave is the multiplier.
interface mult_booth_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output data_operandA,
    output data_operandB,
    output ctrl_MULT,
    input  data_result,
    input  data_exception,
    input  data_resultRDY
  );

  modport slave (
    input  data_operandA,
    input  data_operandB,
    input  ctrl_MULT,
    output data_result,
    output data_exception,
    output data_resultRDY
  );
endinterface

// File: rtl/mult_booth.sv
// Sequential signed 32x32 Booth multiplier: low product word plus signed-overflow flag.
// Radix-2 by default (33-cycle latency); define MULT_BOOTH_RADIX4_EN for radix-4 (17 cycles).
module mult_booth #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic         clock,
  input logic         reset_n,
  mult_booth_if.slave bus
);

`ifdef MULT_BOOTH_RADIX4_EN
  localparam int AW    = WIDTH + 2;
  localparam int SHIFT = 2;
  localparam int STEPS = WIDTH / 2;
`else
  localparam int AW    = WIDTH + 1;
  localparam int SHIFT = 1;
  localparam int STEPS = WIDTH;
`endif
  localparam logic [CNT_W-1:0]     LAST = CNT_W'(STEPS - 1);
  localparam logic signed [AW-1:0] ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic signed [WIDTH-1:0]  m;
  logic signed [AW-1:0]     acc;
  logic [WIDTH-1:0]         q;
  logic                     q_m1;
  logic [WIDTH-1:0]         result;
  logic                     exc;
  logic                     rdy;

  logic signed [AW-1:0]       m_ext;
  logic signed [AW-1:0]       acc_sum;
  logic signed [AW+WIDTH:0]   comb_in;
  logic signed [AW+WIDTH:0]   comb_sh;
  logic signed [AW-1:0]       acc_nx;
  logic [WIDTH-1:0]           q_nx;
  logic                       q_m1_nx;

  // Product fits in WIDTH bits only when P[63:31] is a pure sign extension.
  function automatic logic ovf(input logic [WIDTH:0] hi);
    return !((&hi) || (hi == '0));
  endfunction

  assign m_ext = {{(AW-WIDTH){m[WIDTH-1]}}, m};

`ifdef MULT_BOOTH_RADIX4_EN
  logic signed [AW-1:0] m2;
  assign m2 = m_ext <<< 1;

  always_comb begin
    acc_sum = acc;
    case ({q[1], q[0], q_m1})
      3'b001, 3'b010: acc_sum = acc + m_ext;
      3'b011:         acc_sum = acc + m2;
      3'b100:         acc_sum = acc + ~m2 + ONE;
      3'b101, 3'b110: acc_sum = acc + ~m_ext + ONE;
      default:        acc_sum = acc;
    endcase
  end
`else
  always_comb begin
    acc_sum = acc;
    case ({q[0], q_m1})
      2'b01:   acc_sum = acc + m_ext;
      2'b10:   acc_sum = acc + ~m_ext + ONE;
      default: acc_sum = acc;
    endcase
  end
`endif

  // Arithmetic shift of the whole {A,Q,q_-1} register by the radix step.
  assign comb_in = {acc_sum, q, q_m1};
  assign comb_sh = comb_in >>> SHIFT;
  assign acc_nx  = comb_sh[AW+WIDTH:WIDTH+1];
  assign q_nx    = comb_sh[WIDTH:1];
  assign q_m1_nx = comb_sh[0];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      m      <= '0;
      acc    <= '0;
      q      <= '0;
      q_m1   <= 1'b0;
      result <= '0;
      exc    <= 1'b0;
      rdy    <= 1'b0;
    end else if (bus.ctrl_MULT) begin
      // Start (or abort and restart) from any state.
      m      <= bus.data_operandA;
      q      <= bus.data_operandB;
      acc    <= '0;
      q_m1   <= 1'b0;
      cnt    <= '0;
      state  <= RUN;
      result <= '0;
      exc    <= 1'b0;
      rdy    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          acc  <= acc_nx;
          q    <= q_nx;
          q_m1 <= q_m1_nx;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            result <= q_nx;
            exc    <= ovf({acc_nx[WIDTH-1:0], q_nx[WIDTH-1]});
            rdy    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          rdy   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          rdy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_result    = result;
  assign bus.data_exception = exc;
  assign bus.data_resultRDY = rdy;

endmodule

// File: doc/mult_booth.md
Name: mult_booth

Overview:
- Sequential signed 32x32 multiplier.
- Counterpart to the sequential divider in the multdiv unit, with the same operand/control/result/ready/exception interface shape.
- Radix-2 Booth recoding over a shared accumulator.
- Returns the low 32 bits of the product and flags signed overflow, so the multdiv wrapper treats mult and div uniformly.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is supported; the parameter exists for readability.
- CNT_W, 6, width of the iteration counter.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
- data_operandA  input  32  multiplicand, two's complement.
- data_operandB  input  32  multiplier, two's complement.
- ctrl_MULT  input  1  start strobe; operands are captured on the edge where it is sampled high.
- data_result  output  32  product[31:0].
- data_exception  output  1  high when the signed 64-bit product does not fit in 32 bits.
- data_resultRDY  output  1  one-cycle pulse: data_result and data_exception are valid.

Behaviour:
- Reset: one clock; reset is synchronous and active-low. reset_n=0 at an edge gives:
  - state=IDLE, counter=0, accumulator/Q/q_-1 = 0;
  - data_result=0, data_exception=0, data_resultRDY=0.
  - Reset has priority over ctrl_MULT and aborts any operation in flight.
- States:
  - IDLE -> LOAD on ctrl_MULT. LOAD is not a separate cycle: the load happens on the ctrl_MULT edge.
  - RUN: 32 iterations.
  - DONE: one cycle.
  - DONE -> IDLE.
- Datapath:
  - M = operand A (latched).
  - A = 33-bit sign-extended accumulator, so that M = -2^31 does not overflow on subtract.
  - Q = operand B (latched); q_-1 is an extra bit.
- Load edge E0 (ctrl_MULT=1):
  - M<=operandA, Q<=operandB, A<=0, q_-1<=0, counter<=0, state<=RUN.
  - Operands are ignored after E0.
- RUN step, one per edge E1..E32, on pair {Q[0], q_-1}:
  - 01: A+=M
  - 10: A-=M (via ~M plus carry-in 1)
  - 00/11: no operation.
  - Then arithmetic right shift of {A,Q,q_-1} by 1.
  - counter increments; after the 32nd step, state<=DONE.
- Product P = {A[31:0], Q} (64-bit).
- At E32:
  - data_result <= P[31:0].
  - data_exception <= NOT (P[63:31] all 0 or all 1).
- data_resultRDY:
  - High exactly during the cycle after E32, i.e. the cycle in which state=DONE. Latency is 33 cycles from the start edge to the RDY-high cycle.
  - Falls on the next edge.
- Hold: data_result and data_exception are held after RDY drops, until the next ctrl_MULT edge. At that edge both clear to 0.
- ctrl_MULT high during RUN or DONE: abort and restart with new operands. No RDY is produced for the aborted operation.
- ctrl_MULT held high for multiple cycles: restarts every edge. RDY arrives 33 cycles after the last high sample.
- data_resultRDY is never high in IDLE or RUN.
- Zero operands: run the full 32 iterations. No early termination.

Optional Feature:
- Macro: MULT_BOOTH_RADIX4_EN.
- Defined:
  - Modified-Booth radix-4 is used. Accumulator is 34 bits.
  - Examine {Q[1],Q[0],q_-1}: 0/±M/±2M. Arithmetic right shift by 2.
  - 16 iterations (E1..E16). RDY is high in the cycle after E16, giving latency 17.
  - Results are identical to radix-2.
- Undefined: radix-2 as above, latency 33.

Test Plan:
- Reset: reset_n=0 mid-RUN (after E10) with A=7, B=9 -> next cycle all outputs 0, state IDLE, and no RDY follows within 40 cycles.
- Basic: A=7, B=-3 -> RDY exactly 33 cycles after the start edge (17 with MULT_BOOTH_RADIX4_EN), result=0xFFFFFFEB (-21), exception=0, RDY width 1 cycle.
- Extreme no-overflow: A=0x80000000, B=1 -> result 0x80000000, exception=0. A=-1, B=-1 -> result 1, exception=0.
- Overflow:
  - A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, exception=1.
  - A=0x00010000, B=0x00010000 -> result 0, exception=1.
  - A=0x80000000, B=0x80000000 -> result 0, exception=1.
- Restart: start A=5, B=5; at E20 assert ctrl_MULT with A=6, B=6 -> single RDY 33 cycles after the second start, result=36. Operand inputs changed after E0 have no effect.
- Hold: after RDY for A=12, B=12 (result 144), wait 10 idle cycles -> result stays 144, RDY stays 0. Next start clears result to 0 on the start edge.
